// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding,
// port identifiers, word width and the common 32-bit 2:1 select.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t sel32(input logic sel, input word_t a, input word_t b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// 8-bit BUSY-cycle counter; expired flags the last allowed cycle (LIMIT-1).
module arb_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto a single memory port with
// registered memory-side outputs, completion/timeout pulses and read capture.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned RR_INIT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [WORD_W-1:0] addr0,
  input  logic [WORD_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [WORD_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata
);

  arb_state_t state, next_state;
  logic       owner, last_owner;
  logic       grant, grant_port;
  logic       ack_ok, timed_out;
  logic       expired;

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_port = PORT_IF;
    ack_ok     = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant = 1'b1;
          // Contention goes to the port that did not win last time.
          grant_port = (req0 && req1) ? ~last_owner : req1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          ack_ok     = 1'b1;
          next_state = DONE;
        end else if (expired) begin
          timed_out  = 1'b1;
          next_state = IDLE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  arb_timeout_ctr #(
    .LIMIT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (grant),
    .en     ((state == BUSY) && !mem_ack),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= PORT_IF;
      last_owner <= 1'(RR_INIT);
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      state <= next_state;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      if (grant) begin
        owner      <= grant_port;
        last_owner <= grant_port;
        mem_req    <= 1'b1;
        mem_we     <= grant_port ? we1 : we0;
        mem_addr   <= sel32(grant_port, addr0, addr1);
        mem_wdata  <= sel32(grant_port, wdata0, wdata1);
      end
      if (ack_ok) begin
        mem_req <= 1'b0;
        if (!mem_we) rdata <= mem_rdata;
        if (owner == PORT_DATA) done1 <= 1'b1;
        else                    done0 <= 1'b1;
      end
      if (timed_out) begin
        mem_req <= 1'b0;
        if (owner == PORT_DATA) err1 <= 1'b1;
        else                    err0 <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of BUSY cycles without mem_ack before abort (legal range 2..255).
REQ-002 SHALL have parameter RR_INIT, default 1, meaning the reset value of last_owner.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports req0 / req1, inputs, 1 bit each, transaction request: port 0 is instruction fetch, port 1 is data.
REQ-006 SHALL have ports addr0 / addr1, inputs, 32 bits each, byte address.
REQ-007 SHALL have ports wdata0 / wdata1, inputs, 32 bits each, write data.
REQ-008 SHALL have ports we0 / we1, inputs, 1 bit each, write enable (0 = read).
REQ-009 SHALL have ports done0 / done1, outputs, 1 bit each, one-cycle completion pulse.
REQ-010 SHALL have ports err0 / err1, outputs, 1 bit each, one-cycle timeout pulse.
REQ-011 SHALL have port rdata, output, 32 bits, read data; valid in the done cycle and held until the next completion.
REQ-012 SHALL have ports mem_req, mem_we, outputs, 1 bit each, memory-side strobe and write enable.
REQ-013 SHALL have ports mem_addr, mem_wdata, outputs, 32 bits each, memory-side address and write data.
REQ-014 SHALL have port mem_ack, input, 1 bit, memory completion.
REQ-015 SHALL have port mem_rdata, input, 32 bits, memory read data, valid with mem_ack.

Function
REQ-016 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-017 In IDLE with any req high, SHALL register the owner and that owner's addr/wdata/we, then enter BUSY on the next edge.
REQ-018 Owner selection: a lone requester wins; if req0 and req1 are both high, SHALL grant the port that is not last_owner; last_owner updates at grant.
REQ-019 In BUSY, SHALL hold mem_req=1 and drive mem_addr, mem_wdata and mem_we from the registered copy; these SHALL be stable for the whole of BUSY.
REQ-020 mem_ack in BUSY SHALL latch mem_rdata (reads only; writes leave rdata unchanged) and enter DONE.
REQ-021 DONE SHALL last exactly one cycle: done<owner>=1, mem_req=0, then IDLE.
REQ-022 Minimum latency from req sampled to done pulse SHALL be 2 cycles (mem_ack in the first BUSY cycle).
REQ-023 The timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack.
REQ-024 When the counter reaches TIMEOUT-1 without mem_ack, SHALL pulse err<owner> for one cycle, drop mem_req and go to IDLE; rdata is unchanged.
REQ-025 If mem_ack coincides with the timeout cycle, SHALL treat it as success (done, not err).
REQ-026 Requesters SHALL hold req and attributes until done/err; changes to req or attributes during BUSY are ignored and the transaction completes.
REQ-027 mem_ack outside BUSY SHALL be ignored.
REQ-028 There is no back-to-back grant from DONE; a pending req is re-arbitrated in IDLE.
REQ-029 done0/done1/err0/err1 SHALL be mutually exclusive in any cycle.
REQ-030 All outputs SHALL be driven from registers (no combinational path from req* to mem_*).

Reset
REQ-031 reset_n=0 SHALL asynchronously force: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, all done/err=0, counter=0, last_owner=RR_INIT.
REQ-032 Reset asserted in BUSY SHALL abort the transaction with no done/err pulse.
REQ-033 Reset deassertion SHALL take effect synchronously to clk; the first grant is possible on the first edge after release.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), the port IDs (PORT_IF=0, PORT_DATA=1) and the 32-bit word width constant.
REQ-035 A sub-module arb_timeout_ctr (8-bit counter with clear, enable and expired flag) is natural and SHALL be used.
REQ-036 Address/data steering SHALL reuse the team's 32-bit 2:1 select, with owner as the select.

Verification
REQ-037 req0 alone, addr0=0x00400000 read, mem_ack in the first BUSY cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x00400000, done0 at cycle 2, rdata=0xDEADBEEF.
REQ-038 req0 and req1 simultaneous after reset (RR_INIT=1) -> port 0 granted first; port 1 granted next, done1 after done0.
REQ-039 Sustained dual requests for 4 transactions -> grants alternate 0,1,0,1.
REQ-040 req1 write, addr1=0x10010004, wdata1=0x12345678, no mem_ack -> err1 after TIMEOUT (16) BUSY cycles, mem_req low, rdata unchanged.
REQ-041 mem_ack on the final timeout cycle -> done pulse, no err.
REQ-042 reset_n low mid-BUSY -> mem_req=0 immediately, no done/err; a fresh req after release is granted normally.
